// File: rtl/cdb_result_fifo.sv
// Result queue between the execution units and the CDB arbiter, with first-word-fall-through output.
// Optional same-cycle bypass into an empty queue is enabled by defining CDB_RESULT_FIFO_BYPASS_EN.
module cdb_result_fifo #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             empty, full, push, pop, bypass;

    // Pointers carry a wrap bit above the index so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef CDB_RESULT_FIFO_BYPASS_EN
    assign bypass = empty && !flush_i && wr_valid_i && rd_ready_i;
`else
    assign bypass = 1'b0;
`endif

    assign push = wr_valid_i && !full && !bypass && !flush_i;
    assign pop  = !empty && rd_ready_i && !flush_i;

    assign wr_ready_o    = !full;
    assign full_o        = full;
    assign empty_o       = empty;
    assign count_o       = count_q;
    assign almost_full_o = (count_q >= AF_TH);

    always_comb begin
        rd_valid_o = !empty;
        rd_data_o  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
`ifdef CDB_RESULT_FIFO_BYPASS_EN
        if (empty && !flush_i && wr_valid_i) begin
            rd_valid_o = 1'b1;
            rd_data_o  = wr_data_i;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + PW'(1);
            else if (pop && !push) count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset and flush; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
endmodule

// File: tb/tb_cdb_result_fifo.sv
// Directed bench for cdb_result_fifo: queue-based reference model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_cdb_result_fifo;
    localparam int W  = 64;
    localparam int D  = 8;
    localparam int AF = D - 2;

    logic          clk = 1'b0;
    logic          rst_n, flush_i, wr_valid_i, rd_ready_i;
    logic [W-1:0]  wr_data_i;
    logic          wr_ready_o, rd_valid_o, empty_o, full_o, almost_full_o;
    logic [W-1:0]  rd_data_o;
    logic [3:0]    count_o;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    bit saw_aa = 1'b0;
    logic [W-1:0] q[$];

    cdb_result_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    endtask

`ifdef CDB_RESULT_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Reference: an in-order queue; a packet bypasses only when nothing is queued and the CDB takes it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else if (flush_i) q.delete();
        else begin
            bit take_byp, do_pop, do_push;
            take_byp = BYP && q.size() == 0 && wr_valid_i && rd_ready_i;
            do_pop   = q.size() > 0 && rd_ready_i;
            do_push  = wr_valid_i && q.size() < D && !take_byp;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(wr_data_i);
        end
    end

    function automatic logic exp_rd_valid();
        return q.size() > 0 || (BYP && wr_valid_i && !flush_i);
    endfunction

    function automatic logic [W-1:0] exp_rd_data();
        if (q.size() > 0) return q[0];
        if (BYP && wr_valid_i && !flush_i) return wr_data_i;
        return '0;
    endfunction

    always @(negedge clk) begin
        if (rd_valid_o && rd_data_o == 64'hAA) saw_aa = 1'b1;
        if (chk_en) begin
            chk("model_count",    64'(count_o),       64'(q.size()));
            chk("model_empty",    64'(empty_o),       64'(q.size() == 0));
            chk("model_full",     64'(full_o),        64'(q.size() == D));
            chk("model_afull",    64'(almost_full_o), 64'(q.size() >= AF));
            chk("model_wr_ready", 64'(wr_ready_o),    64'(q.size() < D));
            chk("model_rd_valid", 64'(rd_valid_o),    64'(exp_rd_valid()));
            chk("model_rd_data",  rd_data_o,          exp_rd_data());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"},    64'(count_o),       64'd0);
        chk({tag, "_empty"},    64'(empty_o),       64'd1);
        chk({tag, "_full"},     64'(full_o),        64'd0);
        chk({tag, "_afull"},    64'(almost_full_o), 64'd0);
        chk({tag, "_wr_ready"}, 64'(wr_ready_o),    64'd1);
        chk({tag, "_rd_valid"}, 64'(rd_valid_o),    64'd0);
        chk({tag, "_rd_data"},  rd_data_o,          64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0; wr_data_i = '0;
        step(); step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Fill to full with 0x11..0x88 while the CDB is stalled.
        for (int k = 1; k <= 8; k++) begin
            wr_valid_i = 1'b1; wr_data_i = 64'(8'h11 * k);
            step();
            if (k == 5) chk("afull_at5", 64'(almost_full_o), 64'd0);
            if (k == 6) begin
                chk("afull_at6", 64'(almost_full_o), 64'd1);
                chk("count_at6", 64'(count_o), 64'd6);
            end
        end
        chk("fill_count", 64'(count_o), 64'd8);
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_wr_ready", 64'(wr_ready_o), 64'd0);
        wr_data_i = 64'h99;
        step();
        chk("refused_count", 64'(count_o), 64'd8);
        wr_valid_i = 1'b0;

        // Drain in order.
        rd_ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            chk("drain_data", rd_data_o, 64'(8'h11 * k));
            step();
        end
        chk("drain_empty", 64'(empty_o), 64'd1);
        chk("drain_rd_data", rd_data_o, 64'd0);
        rd_ready_i = 1'b0;

        // Occupancy 3, then 20 cycles of simultaneous push/pop.
        for (int k = 0; k < 3; k++) begin
            wr_valid_i = 1'b1; wr_data_i = 64'(8'hF0 + k);
            step();
        end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr_data_i = 64'(i);
            chk("stream_data", rd_data_o, (i < 3) ? 64'(8'hF0 + i) : 64'(i - 3));
            step();
            chk("stream_count", 64'(count_o), 64'd3);
        end
        wr_valid_i = 1'b0;
        repeat (3) step();
        chk("stream_drained", 64'(empty_o), 64'd1);
        rd_ready_i = 1'b0;

        // Flush at occupancy 5 together with a push of 0xAA.
        for (int k = 0; k < 5; k++) begin
            wr_valid_i = 1'b1; wr_data_i = 64'(8'h30 + k);
            step();
        end
        chk("pre_flush_count", 64'(count_o), 64'd5);
        flush_i = 1'b1; wr_data_i = 64'hAA;
        step();
        flush_i = 1'b0; wr_valid_i = 1'b0;
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_rd_valid", 64'(rd_valid_o), 64'd0);
        wr_valid_i = 1'b1; wr_data_i = 64'h77;
        step();
        wr_valid_i = 1'b0; rd_ready_i = 1'b1;
        chk("post_flush_data", rd_data_o, 64'h77);
        step();
        rd_ready_i = 1'b0;
        chk("no_aa_output", 64'(saw_aa), 64'd0);

        // Asynchronous reset mid-cycle at occupancy 4.
        for (int k = 0; k < 4; k++) begin
            wr_valid_i = 1'b1; wr_data_i = 64'(8'h40 + k);
            step();
        end
        wr_valid_i = 1'b0;
        chk("pre_reset_count", 64'(count_o), 64'd4);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        step();
        rst_n = 1'b1;
        step();
        chk_en = 1'b1;

        // 0x5A into an empty queue with the CDB ready.
        wr_valid_i = 1'b1; wr_data_i = 64'h5A; rd_ready_i = 1'b1;
        #1;
        if (BYP) begin
            chk("byp_rd_valid", 64'(rd_valid_o), 64'd1);
            chk("byp_rd_data", rd_data_o, 64'h5A);
            step();
            wr_valid_i = 1'b0;
            chk("byp_count", 64'(count_o), 64'd0);
        end else begin
            chk("nobyp_rd_valid", 64'(rd_valid_o), 64'd0);
            step();
            wr_valid_i = 1'b0;
            chk("nobyp_count1", 64'(count_o), 64'd1);
            chk("nobyp_rd_data", rd_data_o, 64'h5A);
            step();
            chk("nobyp_count0", 64'(count_o), 64'd0);
        end
        rd_ready_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
